stage_wb: RTL and testbench
===========================

Name: stage_wb

Overview:
Writeback stage of the RV32I multicycle core. It is the writer side of the register-file write port that the decode stage reads through wb_rd/wb_wd/wb_regwrite. It accepts one retired result per handshake from the memory stage and waits for load data when required. It selects the write value by memtoreg, performs load byte/half extraction and sign extension, and commits a single-cycle register write.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
TIMEOUT_CYCLES, 16, load-wait limit; used only when WB_LOAD_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
mem_valid  input  1  memory stage presents a result
mem_ready  output  1  stage can accept a result
mem_rd  input  5  destination register
mem_regwrite  input  1  instruction writes rd
mem_memtoreg  input  2  source select: 00 ALU, 01 load, 10 PC+4, 11 imm
mem_funct3  input  3  load type
mem_alu_result  input  32  ALU result / load address
mem_pc_plus4  input  32  link value
mem_imm  input  32  immediate (LUI)
dmem_rvalid  input  1  load data valid
dmem_rdata  input  32  aligned 32-bit word from data memory
wb_rd  output  5  register-file write address
wb_wd  output  32  register-file write data
wb_regwrite  output  1  register-file write enable, one-cycle pulse
wb_done  output  1  instruction retired, one-cycle pulse
wb_err  output  1  load timeout; tied 0 when the feature is off

Behaviour:
- FSM states: IDLE, WAIT_LOAD, COMMIT.
- Reset (rst=0, async): state=IDLE; wb_rd=0, wb_wd=0, wb_regwrite=0, wb_done=0, wb_err=0; all capture registers cleared; mem_ready=1.
- mem_ready=1 only in IDLE.
- IDLE: on mem_valid&&mem_ready, capture rd, regwrite, memtoreg, funct3, alu_result, pc_plus4, imm.
  - If memtoreg=01, go to WAIT_LOAD.
  - Otherwise load wb_wd from the selected source (00 alu_result, 10 pc_plus4, 11 imm) and go to COMMIT.
- WAIT_LOAD: dmem_rvalid is sampled only in this state. It is ignored in the IDLE capture cycle.
  - On dmem_rvalid, set wb_wd to the extracted value and go to COMMIT.
  - Otherwise stay.
- Load extraction uses off=alu_result[1:0]:
  - 000 LB: sign-extend byte[off].
  - 001 LH: sign-extend half[off[1]]; off[0] ignored.
  - 010 LW: full word; off ignored.
  - 100 LBU: zero-extend byte[off].
  - 101 LHU: zero-extend half[off[1]].
  - Any other funct3: wb_wd=0; still commits.
- COMMIT lasts exactly one cycle, then returns to IDLE.
  - wb_done=1.
  - wb_regwrite = regwrite_q && (rd_q != 0).
  - wb_rd = rd_q.
- Outside COMMIT: wb_regwrite=0 and wb_done=0. wb_rd and wb_wd hold their last values.
- Latency from accept to commit:
  - Non-load: commit in the next cycle; minimum 2 cycles per instruction.
  - Load: commit in the cycle after dmem_rvalid.
- rd=0 with regwrite=1: wb_done pulses, wb_regwrite stays 0.
- Reset mid-WAIT_LOAD or mid-COMMIT: immediate return to IDLE. No write or done pulse is emitted. A dmem_rvalid arriving after reset is ignored.
- mem_valid while not ready: ignored. The memory stage holds its fields until accepted.

Optional Feature:
Macro: WB_LOAD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_LOAD and increments every WAIT_LOAD cycle without dmem_rvalid.
  - When the counter reaches TIMEOUT_CYCLES, the stage goes to IDLE with wb_err=1 for one cycle. There is no wb_regwrite and no wb_done.
  - dmem_rvalid in the same cycle as the limit wins: normal commit.
- Not defined: no counter; WAIT_LOAD waits indefinitely; wb_err is constant 0.

Test Plan:
- ALU op: rd=5, memtoreg=00, alu_result=0x0000_1234, regwrite=1 -> next cycle wb_regwrite=1, wb_rd=5, wb_wd=0x1234, wb_done=1; mem_ready=0 that cycle and 1 after.
- LB: funct3=000, alu_result[1:0]=2, dmem_rdata=0x1180_FF22, rvalid 3 cycles later -> one cycle after rvalid, wb_wd=0xFFFF_FF80; mem_ready=0 throughout the wait.
- LHU/LW: LHU with off=2 on 0xBEEF_0001 -> wb_wd=0x0000_BEEF; LW on the same word -> 0xBEEF_0001.
- JAL/LUI with rd=0: memtoreg=10, pc_plus4=0x104, rd=0 -> wb_done=1, wb_regwrite=0; memtoreg=11, imm=0xABCD_E000, rd=7 -> wb_wd=0xABCD_E000.
- Reset during WAIT_LOAD: drop rst for 1 cycle, then pulse dmem_rvalid -> no wb_regwrite, no wb_done; outputs 0; mem_ready=1.
- Timeout (macro defined, TIMEOUT_CYCLES=16): load with no rvalid -> wb_err pulses after 16 wait cycles, no write, stage back in IDLE; rvalid on the 16th cycle -> normal commit, wb_err=0.

Source files
------------

// File: rtl/stage_wb_if.sv
// Writeback-stage bus: memory-stage handshake, load-data return and register-file write port.
interface stage_wb_if #(
    parameter int XLEN = 32
);
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic            mem_regwrite;
    logic [1:0]      mem_memtoreg;
    logic [2:0]      mem_funct3;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_pc_plus4;
    logic [XLEN-1:0] mem_imm;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_wd;
    logic            wb_regwrite;
    logic            wb_done;
    logic            wb_err;

    modport master (
        output mem_valid, mem_rd, mem_regwrite, mem_memtoreg, mem_funct3,
               mem_alu_result, mem_pc_plus4, mem_imm, dmem_rvalid, dmem_rdata,
        input  mem_ready, wb_rd, wb_wd, wb_regwrite, wb_done, wb_err
    );

    modport slave (
        input  mem_valid, mem_rd, mem_regwrite, mem_memtoreg, mem_funct3,
               mem_alu_result, mem_pc_plus4, mem_imm, dmem_rvalid, dmem_rdata,
        output mem_ready, wb_rd, wb_wd, wb_regwrite, wb_done, wb_err
    );
endinterface

// File: rtl/stage_wb.sv
// RV32I writeback stage: result select, load extraction, one-cycle register-file commit.
// Optional load-wait timeout enabled by defining WB_LOAD_TIMEOUT_EN.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | ready for the next retired result
// WAIT_LOAD | result captured, waiting for dmem_rvalid
// COMMIT    | single-cycle register write / done pulse
module stage_wb #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic       clk,
    input logic       rst,
    stage_wb_if.slave bus
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_LOAD = 2'd1;
    localparam logic [1:0] S_COMMIT    = 2'd2;

    logic [1:0]      r_state;
    logic [4:0]      r_rd;
    logic            r_regwrite;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_wd;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_load;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    always_comb begin
        w_sel = bus.mem_alu_result;
        case (bus.mem_memtoreg)
            2'b10:   w_sel = bus.mem_pc_plus4;
            2'b11:   w_sel = bus.mem_imm;
            default: w_sel = bus.mem_alu_result;
        endcase
    end

    // Extraction works on the captured offset/funct3; the data word arrives later.
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0:    w_byte = bus.dmem_rdata[7:0];
            2'd1:    w_byte = bus.dmem_rdata[15:8];
            2'd2:    w_byte = bus.dmem_rdata[23:16];
            default: w_byte = bus.dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        w_load = '0;
        case (r_funct3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b010:  w_load = bus.dmem_rdata;
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = '0;
        endcase
    end

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_wb_rd    <= '0;
            r_wb_wd    <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
            r_cnt      <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
`ifdef WB_LOAD_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_valid) begin
                        r_rd       <= bus.mem_rd;
                        r_regwrite <= bus.mem_regwrite;
                        r_funct3   <= bus.mem_funct3;
                        r_off      <= bus.mem_alu_result[1:0];
                        if (bus.mem_memtoreg == 2'b01) begin
                            r_state <= S_WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end else begin
                            r_wb_wd <= w_sel;
                            r_wb_rd <= bus.mem_rd;
                            r_state <= S_COMMIT;
                        end
                    end
                end
                S_WAIT_LOAD: begin
                    if (bus.dmem_rvalid) begin
                        r_wb_wd <= w_load;
                        r_wb_rd <= r_rd;
                        r_state <= S_COMMIT;
                    end
`ifdef WB_LOAD_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_COMMIT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_ready   = (r_state == S_IDLE);
    assign bus.wb_done     = (r_state == S_COMMIT);
    assign bus.wb_regwrite = (r_state == S_COMMIT) && r_regwrite && (r_rd != 5'd0);
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_wd       = r_wb_wd;
`ifdef WB_LOAD_TIMEOUT_EN
    assign bus.wb_err      = r_err;
`else
    assign bus.wb_err      = 1'b0;
`endif
endmodule

// File: tb/tb_stage_wb.sv
// Directed self-checking bench for stage_wb.
module tb_stage_wb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_wb_if #(.XLEN(32)) bus();
    stage_wb #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] m2r,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] imm);
        int budget = 0;
        while (!bus.mem_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!bus.mem_ready) check_val("issue_ready_timeout", 32'(bus.mem_ready), 32'd1);
        bus.mem_rd         = rd;
        bus.mem_regwrite   = rw;
        bus.mem_memtoreg   = m2r;
        bus.mem_funct3     = f3;
        bus.mem_alu_result = alu;
        bus.mem_pc_plus4   = pc4;
        bus.mem_imm        = imm;
        bus.mem_valid      = 1'b1;
        tick();
        bus.mem_valid      = 1'b0;
    endtask

    task automatic rvalid_pulse(input logic [31:0] data);
        bus.dmem_rdata  = data;
        bus.dmem_rvalid = 1'b1;
        tick();
        bus.dmem_rvalid = 1'b0;
    endtask

    // Called in the commit cycle; leaves the stage back in IDLE.
    task automatic check_commit(input string tag, input logic rw, input logic [4:0] rd,
                                input logic [31:0] wd);
        check_val({tag, "_done"}, 32'(bus.wb_done), 32'd1);
        check_val({tag, "_regwrite"}, 32'(bus.wb_regwrite), 32'(rw));
        check_val({tag, "_rd"}, 32'(bus.wb_rd), 32'(rd));
        check_val({tag, "_wd"}, bus.wb_wd, wd);
        check_val({tag, "_ready_busy"}, 32'(bus.mem_ready), 32'd0);
        tick();
        check_val({tag, "_ready_after"}, 32'(bus.mem_ready), 32'd1);
        check_val({tag, "_done_after"}, 32'(bus.wb_done), 32'd0);
        check_val({tag, "_wd_hold"}, bus.wb_wd, wd);
    endtask

    typedef struct {
        string       tag;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t lv[5];

    initial begin
        lv[0] = '{"lhu_off2", 5'd3,  3'b101, 32'h0000_2002, 32'hBEEF_0001, 32'h0000_BEEF};
        lv[1] = '{"lw",       5'd4,  3'b010, 32'h0000_2003, 32'hBEEF_0001, 32'hBEEF_0001};
        lv[2] = '{"lh_off3",  5'd11, 3'b001, 32'h0000_3003, 32'h8001_7FFF, 32'hFFFF_8001};
        lv[3] = '{"lbu_off1", 5'd12, 3'b100, 32'h0000_4001, 32'h1180_FF22, 32'h0000_00FF};
        lv[4] = '{"bad_f3",   5'd6,  3'b011, 32'h0000_5000, 32'h1234_5678, 32'h0000_0000};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rd = '0;
        bus.mem_regwrite = 1'b0;
        bus.mem_memtoreg = '0;
        bus.mem_funct3 = '0;
        bus.mem_alu_result = '0;
        bus.mem_pc_plus4 = '0;
        bus.mem_imm = '0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata = '0;
        #12;
        check_val("rst_ready", 32'(bus.mem_ready), 32'd1);
        check_val("rst_wd", bus.wb_wd, 32'd0);
        check_val("rst_rd", 32'(bus.wb_rd), 32'd0);
        check_val("rst_regwrite", 32'(bus.wb_regwrite), 32'd0);
        check_val("rst_done", 32'(bus.wb_done), 32'd0);
        check_val("rst_err", 32'(bus.wb_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ALU result commits the cycle after accept
        issue(5'd5, 1'b1, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
        check_commit("alu", 1'b1, 5'd5, 32'h0000_1234);

        // LB with rvalid present in the capture cycle (must be ignored)
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hDEAD_BEEF;
        issue(5'd9, 1'b1, 2'b01, 3'b000, 32'h0000_1002, 32'h0, 32'h0);
        bus.dmem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_val("lb_wait_ready", 32'(bus.mem_ready), 32'd0);
            check_val("lb_wait_done", 32'(bus.wb_done), 32'd0);
            tick();
        end
        check_val("lb_wait_wd_hold", bus.wb_wd, 32'h0000_1234);
        rvalid_pulse(32'h1180_FF22);
        check_commit("lb", 1'b1, 5'd9, 32'hFFFF_FF80);

        for (int i = 0; i < 5; i++) begin
            issue(lv[i].rd, 1'b1, 2'b01, lv[i].f3, lv[i].addr, 32'h0, 32'h0);
            tick();
            rvalid_pulse(lv[i].word);
            check_commit(lv[i].tag, 1'b1, lv[i].rd, lv[i].exp);
        end

        issue(5'd0, 1'b1, 2'b10, 3'b000, 32'h0, 32'h0000_0104, 32'h0);
        check_commit("jal_rd0", 1'b0, 5'd0, 32'h0000_0104);
        issue(5'd7, 1'b1, 2'b11, 3'b000, 32'h0, 32'h0, 32'hABCD_E000);
        check_commit("lui", 1'b1, 5'd7, 32'hABCD_E000);
        issue(5'd8, 1'b0, 2'b00, 3'b000, 32'h5555_AAAA, 32'h0, 32'h0);
        check_commit("norw", 1'b0, 5'd8, 32'h5555_AAAA);

        // Reset while waiting for load data
        issue(5'd10, 1'b1, 2'b01, 3'b010, 32'h0000_6000, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check_val("rstw_ready", 32'(bus.mem_ready), 32'd1);
        check_val("rstw_wd", bus.wb_wd, 32'd0);
        check_val("rstw_rd", 32'(bus.wb_rd), 32'd0);
        check_val("rstw_done", 32'(bus.wb_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        rvalid_pulse(32'hCAFE_F00D);
        check_val("rstw_late_done", 32'(bus.wb_done), 32'd0);
        check_val("rstw_late_regwrite", 32'(bus.wb_regwrite), 32'd0);
        check_val("rstw_late_ready", 32'(bus.mem_ready), 32'd1);
        tick();
        check_val("rstw_late_done2", 32'(bus.wb_done), 32'd0);
        check_val("rstw_late_wd", bus.wb_wd, 32'd0);

`ifdef WB_LOAD_TIMEOUT_EN
        issue(5'd13, 1'b1, 2'b01, 3'b010, 32'h0000_7000, 32'h0, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        check_val("to_before_ready", 32'(bus.mem_ready), 32'd0);
        check_val("to_before_err", 32'(bus.wb_err), 32'd0);
        tick();
        check_val("to_err", 32'(bus.wb_err), 32'd1);
        check_val("to_ready", 32'(bus.mem_ready), 32'd1);
        check_val("to_done", 32'(bus.wb_done), 32'd0);
        check_val("to_regwrite", 32'(bus.wb_regwrite), 32'd0);
        tick();
        check_val("to_err_pulse", 32'(bus.wb_err), 32'd0);
        issue(5'd14, 1'b1, 2'b01, 3'b010, 32'h0000_7004, 32'h0, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        rvalid_pulse(32'h0BAD_F00D);
        check_val("to_edge_err", 32'(bus.wb_err), 32'd0);
        check_commit("to_edge", 1'b1, 5'd14, 32'h0BAD_F00D);
`else
        issue(5'd13, 1'b1, 2'b01, 3'b010, 32'h0000_7000, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        check_val("nto_ready", 32'(bus.mem_ready), 32'd0);
        check_val("nto_err", 32'(bus.wb_err), 32'd0);
        check_val("nto_done", 32'(bus.wb_done), 32'd0);
        rvalid_pulse(32'h0BAD_F00D);
        check_commit("nto_late", 1'b1, 5'd13, 32'h0BAD_F00D);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
